// File: rtl/module_serial_alu_pkg.sv
// module_serial_alu_pkg: aluop encodings, FSM state type and op legality helper.
package module_serial_alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB || op == OP_SLT;
  endfunction
endpackage

// File: rtl/module_serial_alu_cell.sv
// module_1bit_alu: one-bit ALU cell (and/or/sum/less) with optional b inversion.
module module_1bit_alu (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic       binvert_i,
  input  logic       lessi_i,
  input  logic [1:0] op_i,
  output logic       result_o,
  output logic       cout_o
);
  logic bb, sum;
  always_comb begin
    bb = b_i ^ binvert_i;
    sum = a_i ^ bb ^ cin_i;
    cout_o = (a_i & bb) | (cin_i & (a_i ^ bb));
    result_o = op_i == 2'b00 ? a_i & bb : op_i == 2'b01 ? a_i | bb : op_i == 2'b10 ? sum : lessi_i;
  end
endmodule

// File: rtl/module_serial_alu.sv
// module_serial_alu: bit-serial ALU processing SLICES bits per beat over WIDTH/SLICES beats.
module module_serial_alu
  import module_serial_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SLICES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       aluop_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             cout_o,
  output logic             err_o
);
  localparam int N  = WIDTH / SLICES;
  localparam int CW = $clog2(N + 1);
  if (WIDTH < 2 || WIDTH % SLICES != 0) $error("module_serial_alu: bad WIDTH/SLICES");
  state_t state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, fin_res;
  logic [2:0]       op_q;
  logic             carry_q, accept, last, ovf, legal, arith;
  logic [1:0]       cell_op;
  logic [SLICES:0]  c;
  logic [SLICES-1:0] s;
  assign c[0] = carry_q;
  assign cell_op = op_q == OP_SLT ? 2'b10 : op_q[1:0];
  for (genvar i = 0; i < SLICES; i++) begin : g_cell
    module_1bit_alu u_cell (
      .a_i(a_q[i]), .b_i(b_q[i]), .cin_i(c[i]), .binvert_i(op_q[2]), .lessi_i(1'b0),
      .op_i(cell_op), .result_o(s[i]), .cout_o(c[i+1])
    );
  end
  // The SLT sign fix-up uses the carry into the MSB cell on the final beat.
  always_comb begin
    accept = start_i && state_q != RUN;
    last = state_q == RUN && cnt_q == CW'(N - 1);
    res_d = (res_q >> SLICES) | (WIDTH'(s) << (WIDTH - SLICES));
    ovf = c[SLICES-1] ^ c[SLICES];
    legal = op_legal(op_q);
    arith = op_q == OP_ADD || op_q == OP_SUB;
    fin_res = !legal ? '0 : op_q == OP_SLT ? WIDTH'(res_d[WIDTH-1] ^ ovf) : res_d;
    state_d = state_q == IDLE ? (start_i ? RUN : IDLE)
            : state_q == RUN  ? (last ? FIN : RUN)
            : (start_i ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      op_q <= '0;
      carry_q <= 1'b0;
      result_o <= '0;
      zero_o <= 1'b0;
      overflow_o <= 1'b0;
      cout_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= a_i;
        b_q <= b_i;
        op_q <= aluop_i;
        carry_q <= aluop_i[2];
        cnt_q <= '0;
        res_q <= '0;
      end else if (state_q == RUN) begin
        a_q <= a_q >> SLICES;
        b_q <= b_q >> SLICES;
        carry_q <= c[SLICES];
        cnt_q <= cnt_q + CW'(1);
        res_q <= res_d;
      end
      if (last) begin
        result_o <= fin_res;
        zero_o <= fin_res == '0;
        overflow_o <= arith & ovf;
        cout_o <= arith & c[SLICES];
        err_o <= !legal;
      end
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = state_q == FIN;
endmodule

// File: tb/tb_module_serial_alu.sv
// tb_module_serial_alu: table-driven and scoreboard checks on SLICES=1 and SLICES=4 instances.
module tb_module_serial_alu;
  typedef struct {logic [31:0] res; logic z, v, c, e;} exp_t;
  typedef struct {exp_t e; int cyc;} sb_t;
  typedef struct {logic [2:0] op; logic [31:0] a, b; exp_t e;} vec_t;
  localparam int N1 = 32;
  localparam int N4 = 8;
  logic clk = 0, rst = 1;
  logic start1 = 0, start4 = 0;
  logic [2:0] op1 = 0, op4 = 0;
  logic [31:0] a1 = 0, b1 = 0, a4 = 0, b4 = 0;
  logic busy1, done1, z1, v1, c1, e1, busy4, done4, z4, v4, c4, e4;
  logic [31:0] r1, r4;
  int checks = 0, errors = 0, cyc = 0;
  sb_t q1[$], q4[$];
  vec_t vt[13];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  module_serial_alu #(.WIDTH(32), .SLICES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .aluop_i(op1), .a_i(a1), .b_i(b1),
    .busy_o(busy1), .done_o(done1), .result_o(r1), .zero_o(z1), .overflow_o(v1),
    .cout_o(c1), .err_o(e1));
  module_serial_alu #(.WIDTH(32), .SLICES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .aluop_i(op4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .result_o(r4), .zero_o(z4), .overflow_o(v4),
    .cout_o(c4), .err_o(e4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    logic [32:0] w;
    m = '{res: 32'h0, z: 1'b0, v: 1'b0, c: 1'b0, e: 1'b0};
    case (op)
      3'b000: m.res = a & b;
      3'b001: m.res = a | b;
      3'b010: begin
        w = {1'b0, a} + {1'b0, b};
        m.res = w[31:0]; m.c = w[32];
        m.v = (a[31] == b[31]) && (w[31] != a[31]);
      end
      3'b110: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        m.res = w[31:0]; m.c = w[32];
        m.v = (a[31] != b[31]) && (w[31] != a[31]);
      end
      3'b111: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: m.e = 1'b1;
    endcase
    m.z = m.res == 0;
    return m;
  endfunction

  task automatic cmp(input string tag, input sb_t s, input logic [31:0] r, input logic z,
                     input logic v, input logic c, input logic e);
    chk({tag, " result"}, r, s.e.res);
    chk({tag, " zero"}, 32'(z), 32'(s.e.z));
    chk({tag, " overflow"}, 32'(v), 32'(s.e.v));
    chk({tag, " cout"}, 32'(c), 32'(s.e.c));
    chk({tag, " err"}, 32'(e), 32'(s.e.e));
    chk({tag, " done_cycle"}, 32'(cyc), 32'(s.cyc));
  endtask

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1 unexpected_done at cycle %0d expected no done", cyc);
      end else cmp("d1", q1.pop_front(), r1, z1, v1, c1, e1);
    end
    if (done4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL d4 unexpected_done at cycle %0d expected no done", cyc);
      end else cmp("d4", q4.pop_front(), r4, z4, v4, c4, e4);
    end
  end

  task automatic drain(input bit four);
    int t;
    t = 0;
    while ((four ? q4.size() : q1.size()) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if ((four ? q4.size() : q1.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", four ? q4.size() : q1.size());
      if (four) q4.delete(); else q1.delete();
    end
  endtask

  task automatic run1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(negedge clk);
    start1 = 1; op1 = op; a1 = a; b1 = b;
    q1.push_back('{e: e, cyc: cyc + 1 + N1});
    @(negedge clk);
    start1 = 0; a1 = $urandom; b1 = $urandom; op1 = 3'($urandom);
    drain(0);
  endtask

  initial begin
    int k, bad, dn;
    logic [31:0] ra, rb;
    logic [2:0] rop;
    logic [2:0] legal_ops [5];
    legal_ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    vt[0]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1, 0, 1, 0}};
    vt[1]  = '{3'b110, 32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 0, 1, 1, 0}};
    vt[2]  = '{3'b111, 32'hFFFFFFFE, 32'h00000003, '{32'h00000001, 0, 0, 0, 0}};
    vt[3]  = '{3'b000, 32'h00000005, 32'h00000003, '{32'h00000001, 0, 0, 0, 0}};
    vt[4]  = '{3'b001, 32'hF0F0F0F0, 32'h0F0F0F0F, '{32'hFFFFFFFF, 0, 0, 0, 0}};
    vt[5]  = '{3'b010, 32'h00000003, 32'h00000004, '{32'h00000007, 0, 0, 0, 0}};
    vt[6]  = '{3'b011, 32'h00000005, 32'h00000005, '{32'h00000000, 1, 0, 0, 1}};
    vt[7]  = '{3'b110, 32'h00000005, 32'h00000005, '{32'h00000000, 1, 0, 1, 0}};
    vt[8]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 0, 1, 0, 0}};
    vt[9]  = '{3'b111, 32'h00000003, 32'hFFFFFFFE, '{32'h00000000, 1, 0, 0, 0}};
    vt[10] = '{3'b111, 32'h80000000, 32'h7FFFFFFF, '{32'h00000001, 0, 0, 0, 0}};
    vt[11] = '{3'b100, 32'h0000FFFF, 32'h00000001, '{32'h00000000, 1, 0, 0, 1}};
    vt[12] = '{3'b110, 32'h00000003, 32'h00000005, '{32'hFFFFFFFE, 0, 0, 0, 0}};
    #1;
    chk("reset busy1", 32'(busy1), 0); chk("reset done1", 32'(done1), 0);
    chk("reset result1", r1, 0);
    chk("reset flags1", {27'd0, z1, v1, c1, e1, 1'b0}, 0);
    chk("reset busy4", 32'(busy4), 0); chk("reset result4", r4, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 13; i++) run1(vt[i].op, vt[i].a, vt[i].b, vt[i].e);
    for (int i = 0; i < 12; i++) begin
      rop = legal_ops[$urandom_range(0, 4)]; ra = $urandom; rb = $urandom;
      run1(rop, ra, rb, model(rop, ra, rb));
    end
    // start pulsed during RUN with other operands must be ignored
    @(negedge clk);
    start1 = 1; op1 = 3'b010; a1 = 32'd100; b1 = 32'd23;
    q1.push_back('{e: model(3'b010, 32'd100, 32'd23), cyc: cyc + 1 + N1});
    bad = 0;
    for (int n = 1; n <= N1; n++) begin
      @(negedge clk);
      start1 = (n == 5); op1 = 3'b000; a1 = 32'h12345678; b1 = 32'h0F0F0F0F;
      if (busy1 !== 1'b1) bad++;
    end
    chk("run busy_cycles_low", 32'(bad), 0);
    drain(0);
    // asynchronous reset mid-operation, then a fresh ADD
    @(negedge clk);
    start1 = 1; op1 = 3'b110; a1 = 32'h00000001; b1 = 32'h00000009;
    @(negedge clk);
    start1 = 0;
    repeat (9) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst busy", 32'(busy1), 0); chk("rst done", 32'(done1), 0);
    chk("rst result", r1, 0);
    chk("rst flags", {27'd0, z1, v1, c1, e1, 1'b0}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    dn = 0;
    for (int n = 0; n < N1 + 5; n++) begin
      @(negedge clk);
      if (done1) dn++;
    end
    chk("rst no_done", 32'(dn), 0);
    run1(3'b010, 32'd3, 32'd4, '{32'd7, 0, 0, 0, 0});
    // SLICES=4: AND then OR accepted back-to-back by holding start through FIN
    @(negedge clk);
    start4 = 1; op4 = 3'b000; a4 = 32'hF0F0F0F0; b4 = 32'hFF00FF00;
    k = cyc + 1;
    q4.push_back('{e: '{32'hF000F000, 0, 0, 0, 0}, cyc: k + N4});
    @(negedge clk);
    op4 = 3'b001;
    q4.push_back('{e: '{32'hFFF0FFF0, 0, 0, 0, 0}, cyc: k + N4 + 1 + N4});
    while (cyc < k + N4 + 1) @(negedge clk);
    start4 = 0;
    chk("d4 b2b busy", 32'(busy4), 1);
    drain(1);
    for (int i = 0; i < 6; i++) begin
      rop = (i == 5) ? 3'b101 : legal_ops[$urandom_range(0, 4)]; ra = $urandom; rb = $urandom;
      @(negedge clk);
      start4 = 1; op4 = rop; a4 = ra; b4 = rb;
      q4.push_back('{e: model(rop, ra, rb), cyc: cyc + 1 + N4});
      @(negedge clk);
      start4 = 0;
      drain(1);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/module_serial_alu.md
MODULE_SERIAL_ALU -- requirements
Module: module_serial_alu

Interface
REQ-001 Parameter WIDTH, 32: operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter SLICES, 1: bits processed per cycle; SHALL divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 start  input  1  request; SHALL be sampled only while busy=0.
REQ-006 aluop  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes are illegal.
REQ-007 a, b  input  WIDTH each  operands; SHALL be captured on the accepting edge only.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when result and flags are valid.
REQ-010 result  output  WIDTH  operation result.
REQ-011 zero, overflow, cout, err  output  1 each  result==0; signed overflow; final carry; illegal op.

Function
REQ-012 FSM states SHALL be IDLE, RUN and FIN.
- IDLE->RUN on start.
- RUN->FIN after N=WIDTH/SLICES beats.
- FIN->RUN on start, else FIN->IDLE.
REQ-013 Accept edge SHALL latch a, b and aluop into shift registers, clear the beat counter, and preset carry to aluop[2] (1 for SUB/SLT).
REQ-014 For SUB/SLT, b SHALL be bit-inverted internally.
REQ-015 Each RUN beat SHALL process the SLICES lowest remaining bits through a ripple chain of SLICES 1-bit cells.
- Carry SHALL propagate across beats in a registered carry bit.
- Result bits SHALL shift in from the MSB end.
REQ-016 busy SHALL be 1 exactly during the N RUN cycles; done SHALL be 1 exactly during FIN.
- With an accept at edge k, done SHALL be high in the cycle following edge k+N.
- Latency SHALL be N+1 cycles.
REQ-017 In FIN, for SLT, result SHALL be {WIDTH-1 zeros, sumMSB XOR ovf}, where ovf is carry-into-MSB XOR carry-out.
REQ-018 overflow and cout SHALL reflect ADD/SUB only; both SHALL be 0 for AND/OR/SLT.
REQ-019 zero SHALL equal (result==0) for every op, SLT included.
REQ-020 An illegal aluop SHALL run the full N+1 latency, with result=0, zero=1, overflow=0, cout=0, err=1.
- err SHALL be 0 for all legal ops.
REQ-021 result and flags SHALL update only in FIN and SHALL hold until the next FIN.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 start during FIN SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-024 Addition SHALL wrap modulo 2^WIDTH.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, with busy, done, result, zero, overflow, cout, err, all shift registers, the counter and the carry register at 0.
REQ-026 rst asserted mid-operation SHALL abort the operation with no done pulse.
- After release, the next start SHALL behave as from power-up.
REQ-027 The first start SHALL be sampled on the first rising edge after rst deasserts.

Structure
REQ-028 A shared package SHALL hold the aluop encoding constants and the state typedef.
- The enumeration is IDLE/RUN/FIN.
REQ-029 The beat counter width SHALL be derived as clog2(N+1) in the package or locally.
REQ-030 The per-bit cell SHALL be the existing 1-bit ALU cell (module_1bit_alu), instantiated SLICES times, with lessi tied 0.
- SLT fix-up SHALL be done in FIN, not in the cell.

Verification
REQ-031 WIDTH=32, SLICES=1: ADD a=0xFFFFFFFF, b=0x00000001.
- done 33 cycles after accept.
- Response: result=0, zero=1, cout=1, overflow=0.
REQ-032 SUB a=0x80000000, b=0x00000001.
- Response: result=0x7FFFFFFF, overflow=1, zero=0.
- SLT with a=0xFFFFFFFE (-2), b=0x00000003.
- Response: result=0x00000001, overflow=0.
REQ-033 SLICES=4: AND 0xF0F0F0F0 with 0xFF00FF00, then OR with start held during FIN.
- AND response: done after 9 cycles, result=0xF000F000.
- OR is accepted back-to-back; second done 9 cycles later, result=0xFFF0FFF0.
REQ-034 start pulsed at cycle 5 of RUN with different operands.
- Response: ignored; first result is unchanged and busy stays high through cycle N.
REQ-035 rst asserted at RUN cycle 10.
- Response: busy=0 and all outputs 0 asynchronously; no done pulse.
- Subsequent ADD 3+4 gives result=7.
REQ-036 aluop=011 with a=5, b=5.
- Response: done after N+1 cycles, result=0, zero=1, err=1.
